icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache directly upstream of the fetch stage. Every cycle it takes the fetch stage's next-PC request and returns the registered instruction word tagged with its address one cycle later. On a miss it refills a whole line from the memory port while holding `icache_core_wait_o` high. Registered responses keep the fetch stage's `addr == fetch_pc_q` check cycle-exact.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line (power of 2, ≥2).
- `NUM_LINES`, default 64: number of lines (power of 2).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `icache_core_request_i`  in  1  fetch request valid this cycle.
- `icache_core_pc_i`  in  32  byte address; bits [1:0] ignored.
- `icache_core_wait_o`  out  1  1 = no valid response this cycle.
- `icache_core_addr_o`  out  32  address of the word on `icache_core_out_o`.
- `icache_core_out_o`  out  32  instruction word.
- `icache_flush_i`  in  1  invalidate all lines (fence.i); single-cycle pulse.
- `mem_req_o`  out  1  line refill request.
- `mem_addr_o`  out  32  line-aligned refill address.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`  in  1  refill beat valid.
- `mem_rdata_i`  in  32  refill beat data.
- `hit_cnt_o`  out  32  saturating count of hits.
- `miss_cnt_o`  out  32  saturating count of misses.

## Operation
- Address split:
  - OFF = log2(LINE_WORDS)+2 low bits; word select is pc[OFF-1:2].
  - IDX = log2(NUM_LINES) bits above OFF.
  - Tag is bits [31:OFF+IDX].
- Storage: valid bit, tag and data per line, held in flops/registers and read combinationally in the same cycle.
- FSM states: IDLE, REFILL_REQ, REFILL_DATA.
- IDLE, `icache_core_request_i`=1, hit (valid and tag match):
  - Next cycle `wait_o`=0, `addr_o`=pc_i with bits [1:0] cleared, `out_o`=stored word.
  - `hit_cnt_o` increments.
- IDLE, request=1, miss:
  - Next cycle `wait_o`=1; capture `miss_pc`=pc_i; go to REFILL_REQ.
  - `miss_cnt_o` increments.
- IDLE, request=0: next cycle `wait_o`=1; `addr_o`/`out_o` hold their last values.
- REFILL_REQ:
  - `mem_req_o`=1 and `mem_addr_o`=miss_pc with bits [OFF-1:0] zeroed; both held stable until `mem_gnt_i`.
  - On the cycle `gnt` is seen, go to REFILL_DATA with the beat counter at 0.
  - `mem_rvalid_i` is ignored in REFILL_REQ.
- REFILL_DATA:
  - Each `mem_rvalid_i` writes `mem_rdata_i` into word[beat] of line IDX(miss_pc) and increments the beat counter.
  - Beats arrive in ascending word order from the line base.
  - On beat LINE_WORDS-1: write the tag, set valid (unless `flush_pending`), return to IDLE.
- While not in IDLE: `wait_o`=1, request and pc_i are ignored, counters hold. The core keeps presenting its PC; the first IDLE cycle after a refill re-looks-up whatever pc_i is then (redirects need no special handling).
- `icache_flush_i`:
  - Clears every valid bit at the next edge, in any state.
  - If it arrives in REFILL_REQ/REFILL_DATA, set `flush_pending`; the refill completes but the line is left invalid. `flush_pending` clears on return to IDLE.
  - A lookup in the same cycle as `flush_i` still uses the pre-flush valid bits.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - Outputs: `wait_o`=1, `addr_o`=0, `out_o`=0, `mem_req_o`=0, `mem_addr_o`=0, counters=0.
  - Internal: all valid bits 0, state IDLE, `flush_pending`=0.
- Reset is legal in any state and abandons an in-flight refill; the partially written line stays invalid.
- Hit latency: 1 cycle (sample at edge k, response visible after edge k).
- Back-to-back hits give one response per cycle.
- Miss penalty, with g = cycles from `mem_req_o` rise to `gnt` and b = cycles to receive all beats: `wait_o` is high for 1 + g + b cycles. The next IDLE lookup adds 1 cycle before the hit response.
- `mem_req_o` is registered: it rises the cycle after miss detection and falls the cycle after `gnt`.

## Test plan
- Reset, then request pc=0x0 every cycle with memory `gnt` after 2 cycles and beats 0x13,0x93,0x113,0x193.
  - `wait_o`=1 throughout the refill; `mem_addr_o`=0x0.
  - Then `addr_o`=0x0/`out_o`=0x13, and after that 0x4/0x93 on consecutive cycles; `miss_cnt_o`=1.
- Sequential fetch 0x0–0x1C with LINE_WORDS=4: exactly 2 misses (lines 0x0 and 0x10), 8 valid responses, `hit_cnt_o`=8.
- Conflict: fetch 0x0, then 0x400 (same index with NUM_LINES=64), then 0x0 again → 3 misses; each return shows the correct line data.
- PC redirect mid-refill: miss on 0x20, pc_i changed to 0x100 during REFILL_DATA.
  - Line 0x20 is filled; next IDLE lookup misses on 0x100.
  - The first response is `addr_o`=0x100; no response is ever tagged 0x20.
- `icache_flush_i` pulse during REFILL_DATA for 0x40:
  - The refill completes, but a later fetch of 0x40 misses again.
  - A separate flush pulse in IDLE makes a previously hit line miss.
- Reset asserted in REFILL_DATA after beat 1: `mem_req_o`=0, `wait_o`=1, state IDLE; refetch of the same PC misses.

Source files
------------

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct
// Purpose  : Direct-mapped, read-only instruction cache placed in front of
//            the fetch stage. A lookup is made every cycle. The response is
//            registered, so the fetch stage sees the word and its address one
//            cycle after it presents the PC. On a miss a whole line is
//            refilled from the memory port. Valid, tag and data are held in
//            flops and read combinationally.
// Ports    : clk_i, rst_i                - clock, synchronous active-high reset
//            icache_core_request_i/pc_i  - fetch request and byte address
//            icache_core_wait_o          - 1 = no valid response this cycle
//            icache_core_addr_o/out_o    - address and word of the response
//            icache_flush_i              - invalidate all lines (fence.i)
//            mem_req_o/mem_addr_o        - line refill request, line address
//            mem_gnt_i                   - refill request accepted
//            mem_rvalid_i/mem_rdata_i    - refill beats, ascending word order
//            hit_cnt_o/miss_cnt_o        - saturating hit and miss counters
// Revision : 1.0 - initial release
// ============================================================================
module icache_direct #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        icache_core_request_i,
    input  logic [31:0] icache_core_pc_i,
    output logic        icache_core_wait_o,
    output logic [31:0] icache_core_addr_o,
    output logic [31:0] icache_core_out_o,
    input  logic        icache_flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF    = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF - IDX_W;
    localparam int LINE_W = 32 - OFF;
    localparam int DEPTH  = NUM_LINES * LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REFILL_REQ  = 2'd1,
        ST_REFILL_DATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic [31:0]         data_q [DEPTH];

    // Line number (pc[31:OFF]) of the outstanding miss; index and tag of the
    // line being refilled are both taken from it.
    logic [LINE_W-1:0]   miss_line_q, miss_line_d;
    logic [WSEL_W-1:0]   beat_q, beat_d;
    logic                flush_pending_q, flush_pending_d;

    logic                wait_q, wait_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         out_q, out_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic                data_we;
    logic                tag_we;

    // Lookup path
    logic [IDX_W-1:0]    w_pc_idx;
    logic [WSEL_W-1:0]   w_pc_word;
    logic [TAG_W-1:0]    w_pc_tag;
    logic                w_hit;
    logic [31:0]         w_rd_word;
    logic [IDX_W-1:0]    w_miss_idx;
    logic [TAG_W-1:0]    w_miss_tag;
    logic                w_last_beat;
    logic                w_unused_pc_bits;

    assign w_pc_idx    = icache_core_pc_i[OFF+IDX_W-1:OFF];
    assign w_pc_word   = icache_core_pc_i[OFF-1:2];
    assign w_pc_tag    = icache_core_pc_i[31:OFF+IDX_W];
    assign w_hit       = valid_q[w_pc_idx] && (tag_q[w_pc_idx] == w_pc_tag);
    assign w_rd_word   = data_q[{w_pc_idx, w_pc_word}];
    assign w_miss_idx  = miss_line_q[IDX_W-1:0];
    assign w_miss_tag  = miss_line_q[LINE_W-1:IDX_W];
    assign w_last_beat = (beat_q == WSEL_W'(LINE_WORDS - 1));

    // Byte-offset bits of the PC carry no information for a word fetch.
    assign w_unused_pc_bits = ^icache_core_pc_i[1:0];

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        miss_line_d     = miss_line_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        wait_d          = 1'b1;
        addr_d          = addr_q;
        out_d           = out_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        data_we         = 1'b0;
        tag_we          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush_pending_d = 1'b0;
                if (icache_core_request_i) begin
                    if (w_hit) begin
                        wait_d    = 1'b0;
                        addr_d    = {icache_core_pc_i[31:2], 2'b00};
                        out_d     = w_rd_word;
                        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q
                                                                 : hit_cnt_q + 32'd1;
                    end else begin
                        miss_line_d = icache_core_pc_i[31:OFF];
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {icache_core_pc_i[31:OFF], {OFF{1'b0}}};
                        miss_cnt_d  = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q
                                                                    : miss_cnt_q + 32'd1;
                        // The victim is overwritten beat by beat, so it must
                        // not look valid under its old tag meanwhile.
                        valid_d[w_pc_idx] = 1'b0;
                        state_d     = ST_REFILL_REQ;
                    end
                end
            end

            ST_REFILL_REQ: begin
                if (icache_flush_i) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_REFILL_DATA;
                end
            end

            ST_REFILL_DATA: begin
                if (icache_flush_i) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + WSEL_W'(1);
                    if (w_last_beat) begin
                        tag_we  = 1'b1;
                        // A flush seen at any point of the refill, including
                        // this final beat, leaves the fresh line invalid.
                        valid_d[w_miss_idx] = ~(flush_pending_q | icache_flush_i);
                        flush_pending_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush acts in every state; the lookup above already used the
        // pre-flush valid bits.
        if (icache_flush_i) begin
            valid_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q         <= '0;
            miss_line_q     <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            wait_q          <= 1'b1;
            addr_q          <= '0;
            out_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            valid_q         <= valid_d;
            miss_line_q     <= miss_line_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
            wait_q          <= wait_d;
            addr_q          <= addr_d;
            out_q           <= out_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag and data storage (no reset: qualified by valid_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i && data_we) begin
            data_q[{w_miss_idx, beat_q}] <= mem_rdata_i;
        end
        if (!rst_i && tag_we) begin
            tag_q[w_miss_idx] <= w_miss_tag;
        end
    end

    assign icache_core_wait_o = wait_q;
    assign icache_core_addr_o = addr_q;
    assign icache_core_out_o  = out_q;
    assign mem_req_o          = mem_req_q;
    assign mem_addr_o         = mem_addr_q;
    assign hit_cnt_o          = hit_cnt_q;
    assign miss_cnt_o         = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_direct
// Purpose  : Self-checking bench for icache_direct. A memory responder and
//            the core stimulus are driven from one process; a behavioural
//            cache model tracks expected outputs, and a compare process
//            checks every output on every falling edge. Directed scenarios
//            pin the model with literal expectations, then a randomized run
//            follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 64;
    localparam int OFF        = $clog2(LINE_WORDS) + 2;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wait_o;
    logic [31:0] addr_o;
    logic [31:0] out_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    icache_direct #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .icache_core_request_i (req),
        .icache_core_pc_i      (pc),
        .icache_core_wait_o    (wait_o),
        .icache_core_addr_o    (addr_o),
        .icache_core_out_o     (out_o),
        .icache_flush_i        (flush),
        .mem_req_o             (mem_req_o),
        .mem_addr_o            (mem_addr_o),
        .mem_gnt_i             (gnt),
        .mem_rvalid_i          (rvalid),
        .mem_rdata_i           (rdata),
        .hit_cnt_o             (hit_cnt_o),
        .miss_cnt_o            (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Backing memory contents: word at byte address a is a*32 + 0x13.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a set of resident lines plus the refill in flight
    // ------------------------------------------------------------------
    bit          m_v  [NUM_LINES];
    logic [31:0] m_tg [NUM_LINES];
    bit          m_busy, m_granted, m_fp;
    int          m_beats, m_idx;
    logic [31:0] m_tgmiss;
    logic        exp_wait, exp_req;
    logic [31:0] exp_addr, exp_out, exp_maddr, exp_hit, exp_miss;

    task automatic model_step();
        logic [31:0] line;
        logic [31:0] tg;
        int          idx;
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) m_v[i] = 1'b0;
            m_busy = 0; m_granted = 0; m_fp = 0; m_beats = 0;
            exp_wait = 1'b1; exp_req = 1'b0;
            exp_addr = '0; exp_out = '0; exp_maddr = '0; exp_hit = '0; exp_miss = '0;
        end else begin
            if (!m_busy) begin
                m_fp = 0;
                exp_wait = 1'b1;
                if (req) begin
                    line = pc >> OFF;
                    idx  = int'(line % NUM_LINES);
                    tg   = line / NUM_LINES;
                    if (m_v[idx] && m_tg[idx] == tg) begin
                        exp_wait = 1'b0;
                        exp_addr = pc & ~32'h3;
                        exp_out  = memw(exp_addr);
                        if (exp_hit != 32'hFFFF_FFFF) exp_hit++;
                    end else begin
                        m_busy = 1; m_granted = 0;
                        exp_req   = 1'b1;
                        exp_maddr = line << OFF;
                        if (exp_miss != 32'hFFFF_FFFF) exp_miss++;
                        m_v[idx] = 1'b0;
                        m_idx    = idx;
                        m_tgmiss = tg;
                    end
                end
            end else begin
                exp_wait = 1'b1;
                if (!m_granted) begin
                    if (gnt) begin
                        m_granted = 1; exp_req = 1'b0; m_beats = 0;
                    end
                end else if (rvalid) begin
                    m_beats++;
                    if (m_beats == LINE_WORDS) begin
                        m_busy = 0;
                        m_tg[m_idx] = m_tgmiss;
                        m_v[m_idx]  = !(m_fp || flush);
                    end
                end
                if (flush) m_fp = m_busy;
            end
            if (flush) for (int i = 0; i < NUM_LINES; i++) m_v[i] = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("wait_o",     wait_o,     exp_wait);
            chk("addr_o",     addr_o,     exp_addr);
            chk("out_o",      out_o,      exp_out);
            chk("mem_req_o",  mem_req_o,  exp_req);
            chk("mem_addr_o", mem_addr_o, exp_maddr);
            chk("hit_cnt_o",  hit_cnt_o,  exp_hit);
            chk("miss_cnt_o", miss_cnt_o, exp_miss);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: core inputs plus memory responder, driven at falling edges
    // ------------------------------------------------------------------
    int          rsp_phase = 0;   // 0 idle, 1 awaiting grant, 2 sending beats
    int          rsp_delay = 0;
    int          rsp_beat  = 0;
    logic [31:0] rsp_base  = '0;
    bit          rnd_mem   = 1'b0;

    task automatic drive(input logic rq, input logic [31:0] p, input logic fl, input logic rs);
        rst = rs; req = rq; pc = p; flush = fl;
        gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
        if (rs) begin
            rsp_phase = 0;
        end else begin
            if (rsp_phase == 0) begin
                if (mem_req_o) begin
                    rsp_base  = mem_addr_o;
                    rsp_delay = rnd_mem ? $urandom_range(0, 3) : 1;
                    rsp_phase = 1;
                end else begin
                    rvalid = rnd_mem && ($urandom_range(0, 3) == 0);
                end
            end
            if (rsp_phase == 1) begin
                if (rsp_delay == 0) begin
                    gnt = 1'b1; rsp_phase = 2; rsp_beat = 0;
                end else begin
                    rsp_delay--;
                    rvalid = rnd_mem && ($urandom_range(0, 1) == 0);
                end
            end else if (rsp_phase == 2) begin
                if (!rnd_mem || $urandom_range(0, 3) != 0) begin
                    rvalid = 1'b1;
                    rdata  = memw(rsp_base + 32'(4 * rsp_beat));
                    rsp_beat++;
                    if (rsp_beat == LINE_WORDS) rsp_phase = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] p);
        bit got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            drive(1'b1, p, 1'b0, 1'b0);
            @(negedge clk);
            if (!wait_o && addr_o == p) got = 1;
        end
        if (!got) timeout_fail("fetch");
    endtask

    initial begin : main
        int          n;
        bit          got, sent;
        logic [31:0] p, first_addr, first_out, seqpc;
        int          r;

        rst = 1'b1; req = 1'b0; pc = '0; flush = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        @(negedge clk);
        do_reset();
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        chk("rst_wait",     wait_o,     32'd1);
        chk("rst_addr",     addr_o,     32'd0);
        chk("rst_out",      out_o,      32'd0);
        chk("rst_mem_req",  mem_req_o,  32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_hits",     hit_cnt_o,  32'd0);
        chk("rst_misses",   miss_cnt_o, 32'd0);

        // First miss on 0x0: grant after 2 cycles, 4 back-to-back beats
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        n = 0; got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!wait_o) begin got = 1; break; end
            n++;
            drive(1'b1, 32'h0, 1'b0, 1'b0);
        end
        if (!got) timeout_fail("first_miss");
        chk("miss_wait_cycles", n, 32'd7);
        chk("first_addr", addr_o, 32'h0);
        chk("first_out",  out_o,  32'h13);
        chk("first_misses", miss_cnt_o, 32'd1);
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_wait", wait_o, 32'd0);
        chk("b2b_addr", addr_o, 32'h4);
        chk("b2b_out",  out_o,  32'h93);
        chk("b2b_hits", hit_cnt_o, 32'd2);

        // Sequential 0x0..0x1C from cold
        do_reset();
        for (int a = 0; a < 32; a += 4) fetch(32'(a));
        chk("seq_misses", miss_cnt_o, 32'd2);
        chk("seq_hits",   hit_cnt_o,  32'd8);

        // Conflict on one index
        do_reset();
        fetch(32'h0);   chk("conf_out0",   out_o, 32'h13);
        fetch(32'h400); chk("conf_out400", out_o, 32'h8013);
        fetch(32'h0);   chk("conf_out0b",  out_o, 32'h13);
        chk("conf_misses", miss_cnt_o, 32'd3);

        // PC redirect during refill data
        do_reset();
        p = 32'h20; got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            drive(1'b1, p, 1'b0, 1'b0);
            if (rsp_phase == 2) p = 32'h100;
            @(negedge clk);
            if (!wait_o) begin got = 1; first_addr = addr_o; first_out = out_o; end
        end
        if (!got) timeout_fail("redirect");
        chk("redir_addr",   first_addr, 32'h100);
        chk("redir_out",    first_out,  32'h2013);
        chk("redir_misses", miss_cnt_o, 32'd2);
        fetch(32'h20);
        chk("redir_line20_hit", miss_cnt_o, 32'd2);

        // Flush during refill data of 0x40, then flush while idle
        do_reset();
        sent = 0; got = 0;
        for (int k = 0; k < 80 && !got; k++) begin
            drive(1'b1, 32'h40, (rsp_phase == 2 && rsp_beat == 1 && !sent), 1'b0);
            if (flush) sent = 1;
            @(negedge clk);
            if (!wait_o && addr_o == 32'h40) got = 1;
        end
        if (!got) timeout_fail("flush_refill");
        chk("flush_refill_misses", miss_cnt_o, 32'd2);
        fetch(32'h80);
        fetch(32'h80);
        chk("flush_idle_hit", hit_cnt_o, 32'd3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        fetch(32'h80);
        chk("flush_idle_misses", miss_cnt_o, 32'd4);

        // Reset during refill data after two beats
        do_reset();
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (rsp_phase == 2 && rsp_beat == 2) begin
                drive(1'b1, 32'hC0, 1'b0, 1'b1);
                got = 1;
            end else begin
                drive(1'b1, 32'hC0, 1'b0, 1'b0);
            end
            @(negedge clk);
        end
        if (!got) timeout_fail("reset_refill");
        chk("rstmid_mem_req", mem_req_o,  32'd0);
        chk("rstmid_wait",    wait_o,     32'd1);
        chk("rstmid_misses",  miss_cnt_o, 32'd0);
        fetch(32'hC0);
        chk("rstmid_refetch_misses", miss_cnt_o, 32'd1);

        // Randomized run
        rnd_mem = 1'b1;
        seqpc = 32'h0;
        for (int k = 0; k < 5000; k++) begin
            r = $urandom_range(0, 999);
            if (!wait_o && $urandom_range(0, 3) != 0) seqpc += 32'd4;
            if ($urandom_range(0, 19) == 0) seqpc = 32'($urandom_range(0, 32'h1FFF)) & ~32'h3;
            if ($urandom_range(0, 99) == 0) seqpc = $urandom & ~32'h3;
            drive(($urandom_range(0, 9) < 8), seqpc | 32'($urandom_range(0, 3)),
                  (r >= 3 && r < 15), (r < 3));
            @(negedge clk);
        end

        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
